// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences data-memory accesses for the MEM stage of the 5-stage pipeline.
// A load or store in EX/MEM raises mem_req and holds it until memory answers
// with a one-cycle mem_ack, or until TIMEOUT_CYC wait cycles have elapsed.
// While the access is outstanding the front of the pipe is frozen and a
// bubble is forced into MEM/WB. The completion cycle (DONE) releases the
// stall so MEM/WB captures read_data_from_mem.
//
// Ports:
//   clk                   pipeline clock, all state updates on posedge
//   reset                 synchronous active-low reset
//   ctrl_memRead_ex_mem   load in EX/MEM
//   ctrl_memWrite_ex_mem  store in EX/MEM
//   alu_result_ex_mem     effective address
//   write_data_ex_mem     store data
//   mem_rdata / mem_ack   memory read data and completion pulse
//   err_clr               clears sticky mem_err
//   mem_req / mem_we      memory request and write enable
//   mem_addr / mem_wdata  pass-through address and store data
//   pipe_stall            freezes PC, IF/ID, ID/EX, EX/MEM
//   wb_bubble             zeroes regWrite/memToReg at the MEM/WB input
//   read_data_from_mem    load data toward MEM/WB
//   mem_err               sticky timeout flag
//   stall_count           cycles with pipe_stall=1, saturating
//                         (present only with MEM_ACCESS_STALL_CNT_EN)
//
// State | meaning
// IDLE  | no access outstanding; an access in EX/MEM starts here
// WAIT  | request outstanding, waiting for mem_ack or timeout
// DONE  | completion cycle; stall released, read data presented
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic [31:0] alu_result_ex_mem,
    input  logic [31:0] write_data_ex_mem,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        err_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        pipe_stall,
    output logic        wb_bubble,
    output logic [31:0] read_data_from_mem,
`ifdef MEM_ACCESS_STALL_CNT_EN
    output logic [31:0] stall_count,
`endif
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      rdata_q, rdata_nxt;
    logic             is_read_q, is_read_nxt;
    logic             err_set;
    logic             req_c;
    logic             access;

    assign access = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            is_read_q <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rdata_q   <= rdata_nxt;
            is_read_q <= is_read_nxt;
            // a timeout in the same cycle as err_clr leaves the flag set
            mem_err   <= err_set | (mem_err & ~err_clr);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rdata_nxt   = rdata_q;
        is_read_nxt = is_read_q;
        err_set     = 1'b0;
        req_c       = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    req_c       = 1'b1;
                    state_nxt   = WAIT;
                    cnt_nxt     = '0;
                    is_read_nxt = ctrl_memRead_ex_mem;
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                // ack has priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    state_nxt = DONE;
                    if (is_read_q) begin
                        rdata_nxt = mem_rdata;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    rdata_nxt = '0;
                    err_set   = 1'b1;
                end
            end
            DONE: begin
                // always return to IDLE so the same EX/MEM instruction
                // cannot re-trigger; the next one is decoded fresh
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // request/stall are held low for the whole time reset is asserted
    assign mem_req            = reset & req_c;
    assign pipe_stall         = mem_req;
    assign wb_bubble          = mem_req;
    assign mem_we             = mem_req & ctrl_memWrite_ex_mem;
    assign mem_addr           = alu_result_ex_mem;
    assign mem_wdata          = write_data_ex_mem;
    assign read_data_from_mem = rdata_q;

`ifdef MEM_ACCESS_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (pipe_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
